// File: rtl/digit_scan_selector.sv
// digit_scan_selector: self-scanning CH-channel display selector.
// Holds a per-frame snapshot of the counter bank and steps through the
// channels on a prescaled tick, or follows SEL_IN in manual mode.
// Outputs are registered from the scan index and frame, so they trail an
// index change by one clock. There is no valid/ready handshake: the
// outputs are a continuous, registered display stream.
module digit_scan_selector #(
    parameter  int CH  = 4,
    parameter  int W   = 4,
    parameter  int DIV = 16,
    localparam int SW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CH*W-1:0]   CNT_BUS,
    input  logic              EN,
    input  logic              MODE,
    input  logic [SW-1:0]     SEL_IN,
    input  logic              LZB,
    output logic [W-1:0]      CNT,
    output logic [SW-1:0]     SEL,
    output logic [CH-1:0]     DIG_EN,
    output logic              BLANK
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]   pre_q,   pre_d;
    logic [SW-1:0]   idx_q,   idx_d;
    logic [CH*W-1:0] frame_q, frame_d;

    logic [W-1:0]    cnt_q,   cnt_d;
    logic [SW-1:0]   sel_q,   sel_d;
    logic [CH-1:0]   dig_q,   dig_d;
    logic            blank_q, blank_d;

    logic            tick;
    logic            tail_nz;

    assign tick = (pre_q == PW'(DIV - 1));

    // Scan state: prescaler, channel index and frame snapshot.
    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        if (EN) begin
            if (MODE) begin
                // Manual wins over any pending tick; the frame is transparent.
                pre_d   = '0;
                idx_d   = (SEL_IN > SW'(CH - 1)) ? SW'(CH - 1) : SEL_IN;
                frame_d = CNT_BUS;
            end else if (tick) begin
                pre_d = '0;
                if (idx_q == SW'(CH - 1)) begin
                    // Frame boundary: the only point the bus is sampled.
                    idx_d   = '0;
                    frame_d = CNT_BUS;
                end else begin
                    idx_d = idx_q + SW'(1);
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    // Display outputs derived from the current index and frame.
    always_comb begin
        tail_nz = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (k >= int'(idx_q) && frame_q[k*W +: W] != '0) begin
                tail_nz = 1'b1;
            end
        end
        cnt_d   = frame_q[int'(idx_q)*W +: W];
        sel_d   = idx_q;
        dig_d   = CH'(1) << idx_q;
        blank_d = LZB && (idx_q != '0) && !tail_nz;
        if (!EN) begin
            // Display dark while disabled; SEL keeps showing the held slot.
            cnt_d   = '0;
            sel_d   = sel_q;
            dig_d   = '0;
            blank_d = 1'b1;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            dig_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
        end
    end

    assign CNT    = cnt_q;
    assign SEL    = sel_q;
    assign DIG_EN = dig_q;
    assign BLANK  = blank_q;

endmodule

// File: tb/tb_digit_scan_selector.sv
// Bench for digit_scan_selector: two instances (CH=4/DIV=4 and CH=3/DIV=1)
// checked every cycle against a slot-level model, plus literal expectations.
module tb_digit_scan_selector;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A: CH=4, W=4, DIV=4 ----------------
  logic [15:0] bus_a;
  logic        en_a, mode_a, lzb_a;
  logic [1:0]  sel_in_a;
  logic [3:0]  cnt_a;
  logic [1:0]  sel_a;
  logic [3:0]  dig_a;
  logic        blank_a;

  digit_scan_selector #(.CH(4), .W(4), .DIV(4)) dut_a (
    .CLK(clk), .RST(rst), .CNT_BUS(bus_a), .EN(en_a), .MODE(mode_a),
    .SEL_IN(sel_in_a), .LZB(lzb_a), .CNT(cnt_a), .SEL(sel_a),
    .DIG_EN(dig_a), .BLANK(blank_a)
  );

  // ---------------- DUT B: CH=3, W=4, DIV=1 ----------------
  logic [11:0] bus_b;
  logic        en_b, mode_b, lzb_b;
  logic [1:0]  sel_in_b;
  logic [3:0]  cnt_b;
  logic [1:0]  sel_b;
  logic [2:0]  dig_b;
  logic        blank_b;

  digit_scan_selector #(.CH(3), .W(4), .DIV(1)) dut_b (
    .CLK(clk), .RST(rst), .CNT_BUS(bus_b), .EN(en_b), .MODE(mode_b),
    .SEL_IN(sel_in_b), .LZB(lzb_b), .CNT(cnt_b), .SEL(sel_b),
    .DIG_EN(dig_b), .BLANK(blank_b)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per unit: which slot is on screen, how long it has been there, and the
  // digits of the frame currently being shown.
  int m_pre[2];
  int m_idx[2];
  int m_frame[2][4];
  int m_cnt[2], m_sel[2], m_dig[2], m_blank[2];

  function automatic void m_reset(input int u);
    m_pre[u] = 0; m_idx[u] = 0;
    for (int k = 0; k < 4; k++) m_frame[u][k] = 0;
    m_cnt[u] = 0; m_sel[u] = 0; m_dig[u] = 0; m_blank[u] = 0;
  endfunction

  function automatic void m_load(input int u, input int ch, input logic [15:0] bus);
    for (int k = 0; k < ch; k++) m_frame[u][k] = int'((bus >> (4 * k)) & 16'hF);
  endfunction

  function automatic void m_step(input int u, input int ch, input int div, input bit en,
                                 input bit mode, input int sel_in, input bit lzb,
                                 input logic [15:0] bus);
    bit any_nz;
    if (!en) begin
      m_cnt[u] = 0; m_dig[u] = 0; m_blank[u] = 1;
      return;
    end
    m_cnt[u] = m_frame[u][m_idx[u]];
    m_sel[u] = m_idx[u];
    m_dig[u] = 1 << m_idx[u];
    any_nz = 0;
    for (int k = m_idx[u]; k < ch; k++) if (m_frame[u][k] != 0) any_nz = 1;
    m_blank[u] = (lzb && m_idx[u] != 0 && !any_nz) ? 1 : 0;
    if (mode) begin
      m_pre[u] = 0;
      m_idx[u] = (sel_in < ch) ? sel_in : ch - 1;
      m_load(u, ch, bus);
    end else begin
      m_pre[u]++;
      if (m_pre[u] == div) begin
        m_pre[u] = 0;
        m_idx[u]++;
        if (m_idx[u] == ch) begin
          m_idx[u] = 0;
          m_load(u, ch, bus);
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, 4, 4, en_a, mode_a, int'(sel_in_a), lzb_a, bus_a);
      m_step(1, 3, 1, en_b, mode_b, int'(sel_in_b), lzb_b, {4'h0, bus_b});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk or posedge rst) begin
    #2;
    if (cmp_on) begin
      check("a.cnt",   int'(cnt_a),   m_cnt[0]);
      check("a.sel",   int'(sel_a),   m_sel[0]);
      check("a.dig",   int'(dig_a),   m_dig[0]);
      check("a.blank", int'(blank_a), m_blank[0]);
      check("b.cnt",   int'(cnt_b),   m_cnt[1]);
      check("b.sel",   int'(sel_b),   m_sel[1]);
      check("b.dig",   int'(dig_b),   m_dig[1]);
      check("b.blank", int'(blank_b), m_blank[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_a(input string tag, input int sel, input int cnt, input int dig,
                       input int blank);
    check({tag, ".sel"},   int'(sel_a),   sel);
    check({tag, ".cnt"},   int'(cnt_a),   cnt);
    check({tag, ".dig"},   int'(dig_a),   dig);
    check({tag, ".blank"}, int'(blank_a), blank);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    bus_a = '0; en_a = 1'b0; mode_a = 1'b0; lzb_a = 1'b0; sel_in_a = '0;
    bus_b = 12'h321; en_b = 1'b1; mode_b = 1'b0; lzb_b = 1'b0; sel_in_b = '0;
    cyc(2);
    cmp_on = 1'b1;
    lit_a("reset", 0, 0, 0, 0);

    // Auto scan, first frame still all zero, then 4321.
    en_a = 1'b1; bus_a = 16'h4321; rst = 1'b0;
    cyc(5);  lit_a("scan_e4", 1, 0, 2, 0);
    cyc(12); lit_a("scan_e16", 0, 1, 1, 0);
    check("model_pin.cnt_e16", m_cnt[0], 1);
    cyc(4);  lit_a("scan_e20", 1, 2, 2, 0);

    // Frame coherence: new bus value not shown until the wrap.
    bus_a = 16'h8765;
    cyc(4);  lit_a("coh_e24", 2, 3, 4, 0);
    cyc(4);  lit_a("coh_e28", 3, 4, 8, 0);
    cyc(4);  lit_a("coh_e32", 0, 5, 1, 0);
    check("model_pin.cnt_e32", m_cnt[0], 5);

    // Leading-zero blanking on frame 0030.
    bus_a = 16'h0030; lzb_a = 1'b1;
    cyc(16); lit_a("lzb_s0", 0, 0, 1, 0);
    cyc(4);  lit_a("lzb_s1", 1, 3, 2, 0);
    cyc(4);  lit_a("lzb_s2", 2, 0, 4, 1);
    check("model_pin.blank_s2", m_blank[0], 1);
    cyc(4);  lit_a("lzb_s3", 3, 0, 8, 1);
    lzb_a = 1'b0;
    cyc(12); lit_a("nolzb_s2", 2, 0, 4, 0);

    // Enable drop mid-slot, then resume with the remaining slot cycles.
    en_a = 1'b0;
    cyc(1);  lit_a("en_off", 2, 0, 0, 1);
    cyc(2);
    en_a = 1'b1;
    cyc(3);  lit_a("en_resume", 2, 0, 4, 0);
    cyc(1);  lit_a("en_next", 3, 0, 8, 0);

    // Asynchronous reset between clock edges.
    cyc(1);
    #1 rst = 1'b1;
    #1 lit_a("async_rst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    cyc(1);  lit_a("post_rst_e0", 0, 0, 1, 0);
    cyc(3);  check("post_rst_e3.sel", int'(sel_a), 0);
    cyc(1);  check("post_rst_e4.sel", int'(sel_a), 1);

    // Manual select with transparent frame.
    mode_a = 1'b1; sel_in_a = 2'd2; bus_a = 16'h9ABC;
    cyc(2);  lit_a("man_sel2", 2, 10, 4, 0);
    sel_in_a = 2'd0;
    cyc(1);  check("man_lag.cnt", int'(cnt_a), 10);
    cyc(1);  check("man_sel0.cnt", int'(cnt_a), 12);
    bus_a = 16'h1234;
    cyc(2);  check("man_transp.cnt", int'(cnt_a), 4);
    mode_a = 1'b0;
    cyc(10);

    // CH=3, DIV=1 instance: clamp in manual, then one slot per cycle.
    mode_b = 1'b1; sel_in_b = 2'd3; bus_b = 12'h321;
    cyc(2);
    check("b_clamp.sel", int'(sel_b), 2);
    check("b_clamp.cnt", int'(cnt_b), 3);
    check("b_clamp.dig", int'(dig_b), 4);
    mode_b = 1'b0;
    cyc(1);  check("b_auto0.sel", int'(sel_b), 2);
    cyc(1);  check("b_auto1.sel", int'(sel_b), 0);
             check("b_auto1.cnt", int'(cnt_b), 1);
    cyc(1);  check("b_auto2.sel", int'(sel_b), 1);
             check("b_auto2.cnt", int'(cnt_b), 2);
    cyc(1);  check("b_auto3.sel", int'(sel_b), 2);
             check("b_auto3.dig", int'(dig_b), 4);
    cyc(1);  check("b_auto4.sel", int'(sel_b), 0);

    cmp_on = 1'b0;
    cyc(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
